// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Imported by pc_sequencer and its return-address stack.
package pc_pkg;

    typedef enum logic [2:0] {
        NXT_INC,
        NXT_ABS,
        NXT_REL,
        NXT_CALL,
        NXT_RET
    } next_sel_t;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic [31:0] sext32(
        input logic [31:0] v,
        input int unsigned w
    );
        logic signed [31:0] s;
        s = $signed(v << (32 - w));
        return $unsigned(s >>> (32 - w));
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of D-bit addresses.
// Pushes are dropped when full and pops are dropped when empty.
module ras_stack #(
    parameter int D         = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [D-1:0]  mem [RAS_DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] tos;

    assign tos   = cnt - 1'b1;
    assign full  = (cnt == CW'(RAS_DEPTH));
    assign empty = (cnt == '0);
    assign top   = empty ? '0 : mem[tos[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[cnt[AW-1:0]] <= din;
            cnt              <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds prog_ctr for CPI cycles,
// then commits one next-PC decision (inc/branch/call/ret).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int             D         = 12,
    parameter int             CPI       = 12,
    parameter int             OFF_W     = 8,
    parameter int             RAS_DEPTH = 4,
    parameter logic [D-1:0]   RESET_PC  = '0,
    localparam int            PW        = (CPI > 1) ? $clog2(CPI) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             branch_rel,
    input  logic [D-1:0]     target,
    input  logic [OFF_W-1:0] offset,
    input  logic             call,
    input  logic             ret,
    output logic [D-1:0]     prog_ctr,
    output logic             step,
    output logic [PW-1:0]    phase,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             fault
);

    localparam logic [PW-1:0] LAST = PW'(CPI - 1);

    next_sel_t   sel;
    logic        commit;
    logic        fault_set;
    logic        push;
    logic        pop;
    logic [31:0] off_x;
    logic [D-1:0] ras_top;
    logic [D-1:0] pc_inc;
    logic [D-1:0] pc_nxt;

    assign commit = !stall && (phase == LAST);
    assign off_x  = sext32(32'(offset), OFF_W);
    assign pc_inc = prog_ctr + 1'b1;

    // Lower-priority strobes are masked so they never act.
    always_comb begin
        sel = NXT_INC;
        unique case (1'b1)
            ret:                     sel = ras_empty ? NXT_INC : NXT_RET;
            !ret && call:            sel = ras_full ? NXT_INC : NXT_CALL;
            !ret && !call && branch_en:
                                     sel = branch_rel ? NXT_REL : NXT_ABS;
            default:                 sel = NXT_INC;
        endcase
    end

    always_comb begin
        pc_nxt = pc_inc;
        unique case (sel)
            NXT_ABS:  pc_nxt = target;
            NXT_REL:  pc_nxt = prog_ctr + off_x[D-1:0];
            NXT_CALL: pc_nxt = target;
            NXT_RET:  pc_nxt = ras_top;
            default:  pc_nxt = pc_inc;
        endcase
    end

    assign push      = commit && (sel == NXT_CALL);
    assign pop       = commit && (sel == NXT_RET);
    assign fault_set = commit &&
                       ((ret && ras_empty) || (!ret && call && ras_full));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            prog_ctr <= RESET_PC;
            step     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            step  <= commit;
            fault <= fault | fault_set;
            if (!stall) begin
                phase <= (phase == LAST) ? '0 : phase + 1'b1;
            end
            if (commit) begin
                prog_ctr <= pc_nxt;
            end
        end
    end

    ras_stack #(
        .D         (D),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .top     (ras_top),
        .full    (ras_full),
        .empty   (ras_empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based
// behavioural model of the commit rules.
module tb_pc_sequencer;

    localparam int D     = 12;
    localparam int CPI   = 12;
    localparam int OFF_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             stall;
    logic             branch_en;
    logic             branch_rel;
    logic [D-1:0]     target;
    logic [OFF_W-1:0] offset;
    logic             call;
    logic             ret;
    logic [D-1:0]     prog_ctr;
    logic             step;
    logic [3:0]       phase;
    logic             ras_empty;
    logic             ras_full;
    logic             fault;

    int n_chk  = 0;
    int n_pass = 0;

    int           m_ph;
    logic [D-1:0] m_pc;
    logic [D-1:0] stk[$];
    logic         m_fault;
    logic         m_step;

    pc_sequencer #(
        .D         (D),
        .CPI       (CPI),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (12'h000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_rel (branch_rel),
        .target     (target),
        .offset     (offset),
        .call       (call),
        .ret        (ret),
        .prog_ctr   (prog_ctr),
        .step       (step),
        .phase      (phase),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic m_rst();
        m_ph    = 0;
        m_pc    = 12'h000;
        m_fault = 1'b0;
        m_step  = 1'b0;
        stk.delete();
    endtask

    task automatic m_edge();
        int sum;
        m_step = 1'b0;
        if (stall) return;
        if (m_ph != CPI - 1) begin
            m_ph++;
            return;
        end
        m_ph   = 0;
        m_step = 1'b1;
        if (ret) begin
            if (stk.size() != 0) m_pc = stk.pop_back();
            else begin
                m_pc    = 12'(m_pc + 12'd1);
                m_fault = 1'b1;
            end
        end else if (call) begin
            if (stk.size() < DEPTH) begin
                stk.push_back(12'(m_pc + 12'd1));
                m_pc = target;
            end else begin
                m_pc    = 12'(m_pc + 12'd1);
                m_fault = 1'b1;
            end
        end else if (branch_en) begin
            if (branch_rel) begin
                sum  = int'(m_pc) + int'($signed(offset));
                m_pc = 12'(sum & 32'hFFF);
            end else begin
                m_pc = target;
            end
        end else begin
            m_pc = 12'(m_pc + 12'd1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset_n) m_rst();
        else m_edge();
        #1;
    endtask

    task automatic zero_in();
        branch_en  = 1'b0;
        branch_rel = 1'b0;
        call       = 1'b0;
        ret        = 1'b0;
        target     = '0;
        offset     = '0;
    endtask

    task automatic rand_in();
        branch_en  = 1'($urandom);
        branch_rel = 1'($urandom);
        call       = 1'($urandom);
        ret        = 1'($urandom);
        target     = 12'($urandom);
        offset     = 8'($urandom);
    endtask

    // Non-commit cycles carry random strobes that must be ignored.
    task automatic do_instr(input bit r, input bit c, input bit b,
                            input bit rel, input logic [D-1:0] t,
                            input logic [OFF_W-1:0] o);
        int guard = 0;
        stall = 1'b0;
        while (m_ph != CPI - 1 && guard < 100) begin
            rand_in();
            cyc();
            guard++;
        end
        ret        = r;
        call       = c;
        branch_en  = b;
        branch_rel = rel;
        target     = t;
        offset     = o;
        cyc();
        zero_in();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall   = 1'b0;
        zero_in();
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall   = 1'b0;
        zero_in();
        m_rst();
        cyc();
        cyc();
        n_chk++;
        if (prog_ctr !== 12'h000) $display("FAIL rst_pc got %h exp 000", prog_ctr);
        else n_pass++;
        n_chk++;
        if (phase !== 4'd0) $display("FAIL rst_phase got %0d exp 0", phase);
        else n_pass++;
        n_chk++;
        if (step !== 1'b0) $display("FAIL rst_step got %b exp 0", step);
        else n_pass++;
        n_chk++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0)
            $display("FAIL rst_ras got e%b f%b exp e1 f0", ras_empty, ras_full);
        else n_pass++;
        n_chk++;
        if (fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", fault);
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_free_run();
        int steps = 0;
        for (int e = 1; e <= 36; e++) begin
            cyc();
            if (step === 1'b1) steps++;
            n_chk++;
            if (prog_ctr !== 12'(e / CPI) || step !== ((e % CPI) == 0))
                $display("FAIL free_run edge %0d got pc %h step %b exp pc %h step %b",
                         e, prog_ctr, step, 12'(e / CPI), (e % CPI) == 0);
            else n_pass++;
        end
        n_chk++;
        if (steps != 3) $display("FAIL free_run_steps got %0d exp 3", steps);
        else n_pass++;
    endtask

    task automatic test_rel();
        do_instr(0, 0, 1, 0, 12'h010, 8'h00);
        n_chk++;
        if (prog_ctr !== 12'h010) $display("FAIL abs_010 got %h exp 010", prog_ctr);
        else n_pass++;
        do_instr(0, 0, 1, 1, 12'h000, 8'hF0);
        n_chk++;
        if (prog_ctr !== 12'h000 || m_pc !== 12'h000)
            $display("FAIL rel_neg got %h exp 000", prog_ctr);
        else n_pass++;
        do_instr(0, 0, 1, 0, 12'h010, 8'h00);
        do_instr(0, 0, 1, 1, 12'h000, 8'h7F);
        n_chk++;
        if (prog_ctr !== 12'h08F) $display("FAIL rel_pos got %h exp 08F", prog_ctr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_instr(0, 0, 1, 0, 12'hFFF, 8'h00);
        do_instr(0, 0, 0, 0, 12'h000, 8'h00);
        n_chk++;
        if (prog_ctr !== 12'h000 || step !== 1'b1)
            $display("FAIL wrap got pc %h step %b exp pc 000 step 1", prog_ctr, step);
        else n_pass++;
    endtask

    task automatic test_call_ret();
        do_instr(0, 0, 1, 0, 12'h020, 8'h00);
        do_instr(0, 1, 0, 0, 12'h300, 8'h00);
        n_chk++;
        if (prog_ctr !== 12'h300 || ras_empty !== 1'b0)
            $display("FAIL call got pc %h empty %b exp pc 300 empty 0",
                     prog_ctr, ras_empty);
        else n_pass++;
        do_instr(0, 0, 0, 0, 12'h000, 8'h00);
        do_instr(0, 0, 0, 0, 12'h000, 8'h00);
        do_instr(1, 0, 0, 0, 12'h000, 8'h00);
        n_chk++;
        if (prog_ctr !== 12'h021 || ras_empty !== 1'b1)
            $display("FAIL ret got pc %h empty %b exp pc 021 empty 1",
                     prog_ctr, ras_empty);
        else n_pass++;
    endtask

    task automatic test_nested();
        logic [D-1:0] exp_ret [4];
        exp_ret = '{12'h401, 12'h301, 12'h201, 12'h101};
        do_reset();
        do_instr(0, 0, 1, 0, 12'h100, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            do_instr(0, 1, 0, 0, 12'(i * 256 + 256), 8'h00);
        end
        n_chk++;
        if (prog_ctr !== 12'h500 || ras_full !== 1'b1 || fault !== 1'b0)
            $display("FAIL call4 got pc %h full %b fault %b exp pc 500 full 1 fault 0",
                     prog_ctr, ras_full, fault);
        else n_pass++;
        do_instr(0, 1, 0, 0, 12'h600, 8'h00);
        n_chk++;
        if (prog_ctr !== 12'h501 || ras_full !== 1'b1 || fault !== 1'b1)
            $display("FAIL call5 got pc %h full %b fault %b exp pc 501 full 1 fault 1",
                     prog_ctr, ras_full, fault);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            do_instr(1, 0, 0, 0, 12'h000, 8'h00);
            n_chk++;
            if (prog_ctr !== exp_ret[i])
                $display("FAIL unwind %0d got %h exp %h", i, prog_ctr, exp_ret[i]);
            else n_pass++;
        end
        n_chk++;
        if (ras_empty !== 1'b1 || fault !== 1'b1)
            $display("FAIL unwind_end got empty %b fault %b exp empty 1 fault 1",
                     ras_empty, fault);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 11; i++) cyc();
        n_chk++;
        if (phase !== 4'd11) $display("FAIL pre_stall_phase got %0d exp 11", phase);
        else n_pass++;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_in();
            cyc();
            n_chk++;
            if (phase !== 4'd11 || step !== 1'b0 || prog_ctr !== 12'h000 ||
                ras_empty !== 1'b1)
                $display("FAIL stall %0d got ph %0d step %b pc %h exp ph 11 step 0 pc 000",
                         i, phase, step, prog_ctr);
            else n_pass++;
        end
        stall = 1'b0;
        zero_in();
        cyc();
        n_chk++;
        if (step !== 1'b1 || prog_ctr !== 12'h001 || phase !== 4'd0)
            $display("FAIL unstall got step %b pc %h ph %0d exp step 1 pc 001 ph 0",
                     step, prog_ctr, phase);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        do_instr(0, 0, 1, 0, 12'h040, 8'h00);
        do_instr(0, 1, 0, 0, 12'h050, 8'h00);
        do_instr(0, 1, 0, 0, 12'h060, 8'h00);
        do_instr(1, 1, 1, 0, 12'h700, 8'h00);
        n_chk++;
        if (prog_ctr !== 12'h051 || ras_empty !== 1'b0 || ras_full !== 1'b0)
            $display("FAIL prio got pc %h e%b f%b exp pc 051 e0 f0",
                     prog_ctr, ras_empty, ras_full);
        else n_pass++;
        do_instr(1, 0, 0, 0, 12'h000, 8'h00);
        n_chk++;
        if (prog_ctr !== 12'h041 || ras_empty !== 1'b1 || fault !== 1'b0)
            $display("FAIL prio_depth got pc %h e%b fault %b exp pc 041 e1 fault 0",
                     prog_ctr, ras_empty, fault);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        do_instr(0, 1, 0, 0, 12'h123, 8'h00);
        do_instr(1, 0, 0, 0, 12'h000, 8'h00);
        do_instr(1, 0, 0, 0, 12'h000, 8'h00);
        do_instr(0, 1, 0, 0, 12'h234, 8'h00);
        while (m_ph != 6 && guard < 50) begin
            cyc();
            guard++;
        end
        n_chk++;
        if (phase !== 4'd6 || fault !== 1'b1 || ras_empty !== 1'b0)
            $display("FAIL pre_rst got ph %0d fault %b e%b exp ph 6 fault 1 e0",
                     phase, fault, ras_empty);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (prog_ctr !== 12'h000 || phase !== 4'd0 || step !== 1'b0 ||
            ras_empty !== 1'b1 || ras_full !== 1'b0 || fault !== 1'b0)
            $display("FAIL mid_rst got pc %h ph %0d step %b e%b f%b fault %b",
                     prog_ctr, phase, step, ras_empty, ras_full, fault);
        else n_pass++;
        m_rst();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        bit r, c, b, rel;
        for (int n = 0; n < 40; n++) begin
            r   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 3) == 0);
            b   = 1'($urandom);
            rel = 1'($urandom);
            do_instr(r, c, b, rel, 12'($urandom), 8'($urandom));
            n_chk++;
            if (prog_ctr !== m_pc || step !== m_step || fault !== m_fault ||
                ras_empty !== (stk.size() == 0) || ras_full !== (stk.size() == DEPTH))
                $display("FAIL random %0d got pc %h step %b fault %b e%b f%b exp pc %h step %b fault %b depth %0d",
                         n, prog_ctr, step, fault, ras_empty, ras_full,
                         m_pc, m_step, m_fault, stk.size());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_rel();
        test_wrap();
        test_call_ret();
        test_nested();
        test_stall();
        test_priority();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
